pc_predictor: RTL and testbench
===============================

# pc_predictor

Fetch-stage program counter with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it presents `fetch_pc` and a prediction for the next PC. When the execute stage resolves a branch or jump, it takes that resolution, trains the BTB and, on a misprediction, redirects fetch and raises a flush. It replaces the plain PC register in the fetch stage and sits between the fetch logic and the execute-stage branch unit.

## Interface
- `DBITS`, 32, data/address width
- `START_PC`, 64, `fetch_pc` value after reset
- `BTB_ENTRIES`, 16, BTB depth; power of two, >= 2; index bits `IW = log2(BTB_ENTRIES)`
- `CNT_BITS`, 16, width of the misprediction counter
- `clk` in 1: single clock, all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `enable` in 1: fetch advance; 0 = stall (`fetch_pc` holds unless a redirect occurs)
- `fetch_pc` out DBITS: current fetch address (registered)
- `pred_taken` out 1: prediction for `fetch_pc` (combinational from `fetch_pc` and BTB state)
- `pred_target` out DBITS: predicted next PC; equals `fetch_pc+4` when `pred_taken`=0
- `res_valid` in 1: resolution present this cycle
- `res_pc` in DBITS: PC of the resolving instruction
- `res_is_branch` in 1: instruction is a branch or jump
- `res_taken` in 1: actual direction
- `res_target` in DBITS: actual taken target, computed by execute
- `res_pred_taken` in 1: `pred_taken` carried down the pipe with the instruction
- `res_pred_target` in DBITS: `pred_target` carried with the instruction
- `flush` out 1: combinational; 1 in the same cycle a misprediction is resolved
- `mispredict_count` out CNT_BITS: saturating count of mispredictions

## Operation
- BTB entry fields: `valid`, `tag` (`pc[DBITS-1:IW+2]`), `target` (DBITS), `ctr` (2 bits). Index is `pc[IW+1:2]`.
- **Lookup.** A hit requires the indexed entry to be valid with a matching tag.
  - `pred_taken` = hit && `ctr[1]`.
  - `pred_target` = `target` when `pred_taken`=1, else `fetch_pc+4`.
- **Actual next PC.** `actual` = `res_taken` ? `res_target` : `res_pc+4`. For a non-branch (`res_is_branch`=0), `actual` = `res_pc+4`.
- **Misprediction.** `mispredict` = `res_valid` && (`res_pred_taken` != actual direction, or `res_pred_target` != `actual`). Actual direction is `res_taken` && `res_is_branch`.
- **Next-PC priority:**
  1. `reset` → `START_PC`.
  2. `mispredict` → `actual`, regardless of `enable`.
  3. `enable` → `pred_target`.
  4. Otherwise hold.
- **Training on `res_valid` with `res_is_branch`=1**, indexed by `res_pc`:
  - Hit and taken: `ctr` increments, saturating at 3; `target` ← `res_target`.
  - Hit and not-taken: `ctr` decrements, saturating at 0; `target` unchanged.
  - Miss and taken: allocate/overwrite the entry with `valid`=1, tag, `target`=`res_target`, `ctr`=2.
  - Miss and not-taken: no change.
- **`res_is_branch`=0 with a hit** (alias): clear `valid` on that entry.
- **`mispredict_count`** increments by 1 on each `mispredict` and saturates at all-ones.
- **Reset** clears every `valid` bit and zeroes `mispredict_count`. Target and counter contents are don't-care.

## Timing
- Reset values:
  - `fetch_pc`=`START_PC`.
  - `pred_taken`=0 and `pred_target`=`START_PC+4`, because the BTB is empty.
  - `flush`=0 (given `res_valid`=0).
  - `mispredict_count`=0.
- Lookup latency 0: the prediction is valid in the same cycle as `fetch_pc`.
- Redirect latency 1: `mispredict` in cycle N gives `fetch_pc`=`actual` in cycle N+1, and `flush`=1 in cycle N only.
- BTB writes become visible on the cycle after the edge. A same-cycle lookup of the index being trained sees the old contents.
- `reset` asserted mid-operation overrides redirect and training on that edge.
- All arithmetic is modulo 2^DBITS. `fetch_pc+4` wraps from all-ones-minus-3 to 0.
- At most one resolution per cycle. There is no backpressure on the resolution port.

## Test plan
- Reset, then `enable`=1 for 3 cycles with no resolutions → `fetch_pc` sequence 64, 68, 72, 76; `pred_taken`=0 throughout.
- Resolve `res_pc`=72 as taken to 200 with `res_pred_taken`=0 → `flush`=1 that cycle, next `fetch_pc`=200, `mispredict_count`=1. When `fetch_pc` later reaches 72: `pred_taken`=1, `pred_target`=200.
- Train the same branch not-taken twice, starting from `ctr`=2 → after the first, `ctr`=1 and `pred_taken`=0 at 72. The second gives `ctr`=0 and no flush, because `res_pred_taken`=0 matches.
- `enable`=0 with a mispredict on `res_pc`=100, not-taken → `fetch_pc`=104 next cycle despite the stall.
- Assert `reset` in the same cycle as a mispredict → `fetch_pc`=64, BTB cleared, `mispredict_count`=0.
- Drive `CNT_BITS` all-ones mispredictions plus one more → count holds at all-ones. Also repeat the first scenario with `BTB_ENTRIES`=4 to check aliasing invalidation with `res_is_branch`=0.

Source files
------------

// File: rtl/pc_predictor_if.sv
// Fetch and resolution signals between the fetch logic, the execute-stage
// branch unit and the PC predictor.
interface pc_predictor_if #(
    parameter int unsigned DBITS = 32
);
    // Fetch side.
    logic             enable;
    logic [DBITS-1:0] fetch_pc;
    logic             pred_taken;
    logic [DBITS-1:0] pred_target;

    // Resolution port. res_valid qualifies every res_* field in the same cycle.
    // There is no ready: each cycle with res_valid=1 is consumed on that edge.
    logic             res_valid;
    logic [DBITS-1:0] res_pc;
    logic             res_is_branch;
    logic             res_taken;
    logic [DBITS-1:0] res_target;
    logic             res_pred_taken;
    logic [DBITS-1:0] res_pred_target;
    logic             flush;

    modport master (
        output enable, res_valid, res_pc, res_is_branch, res_taken,
               res_target, res_pred_taken, res_pred_target,
        input  fetch_pc, pred_taken, pred_target, flush
    );

    modport slave (
        input  enable, res_valid, res_pc, res_is_branch, res_taken,
               res_target, res_pred_taken, res_pred_target,
        output fetch_pc, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/pc_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit direction
// counters, trained and redirected by execute-stage branch resolutions.
module pc_predictor #(
    parameter int unsigned      DBITS       = 32,
    parameter logic [DBITS-1:0] START_PC    = 64,
    parameter int unsigned      BTB_ENTRIES = 16,
    parameter int unsigned      CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                reset,
    pc_predictor_if.slave       bus,
    output logic [CNT_BITS-1:0] mispredict_count
);
    localparam int unsigned      IW      = $clog2(BTB_ENTRIES);
    localparam int unsigned      TW      = DBITS - IW - 2;
    localparam logic [DBITS-1:0] PC_STEP = DBITS'(4);

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
    logic [DBITS-1:0]       btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IW-1:0]    f_idx;
    logic [TW-1:0]    f_tag;
    logic             f_hit;
    logic [IW-1:0]    r_idx;
    logic [TW-1:0]    r_tag;
    logic             r_hit;
    logic             actual_taken;
    logic [DBITS-1:0] actual;
    logic             mispredict;
    logic [DBITS-1:0] next_pc;

    // Lookup for the current fetch address.
    assign f_idx = bus.fetch_pc[IW+1:2];
    assign f_tag = bus.fetch_pc[DBITS-1:IW+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign bus.pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign bus.pred_target = bus.pred_taken ? btb_target[f_idx] : bus.fetch_pc + PC_STEP;

    // Resolution side: what really happened and whether the carried prediction agreed.
    assign r_idx        = bus.res_pc[IW+1:2];
    assign r_tag        = bus.res_pc[DBITS-1:IW+2];
    assign r_hit        = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
    assign actual_taken = bus.res_taken && bus.res_is_branch;
    assign actual       = actual_taken ? bus.res_target : bus.res_pc + PC_STEP;
    assign mispredict   = bus.res_valid &&
                          ((bus.res_pred_taken != actual_taken) ||
                           (bus.res_pred_target != actual));
    assign bus.flush    = mispredict;

    always_comb begin
        next_pc = bus.fetch_pc;
        if (mispredict) begin
            next_pc = actual;
        end else if (bus.enable) begin
            next_pc = bus.pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.fetch_pc <= START_PC;
        end else begin
            bus.fetch_pc <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count <= '0;
        end else if (mispredict && (mispredict_count != {CNT_BITS{1'b1}})) begin
            mispredict_count <= mispredict_count + 1'b1;
        end
    end

    // Valid bits are the only BTB state that needs reset; a non-branch that
    // hits means the entry describes stale code, so it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid <= '0;
        end else if (bus.res_valid) begin
            if (bus.res_is_branch) begin
                if (bus.res_taken) begin
                    btb_valid[r_idx] <= 1'b1;
                end
            end else if (r_hit) begin
                btb_valid[r_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && bus.res_valid && bus.res_is_branch) begin
            if (r_hit) begin
                if (bus.res_taken) begin
                    btb_target[r_idx] <= bus.res_target;
                    if (btb_ctr[r_idx] != 2'd3) begin
                        btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
                    end
                end else if (btb_ctr[r_idx] != 2'd0) begin
                    btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
                end
            end else if (bus.res_taken) begin
                btb_tag[r_idx]    <= r_tag;
                btb_target[r_idx] <= bus.res_target;
                btb_ctr[r_idx]    <= 2'd2;
            end
        end
    end
endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: a default-size instance and a small
// instance (4-entry BTB, 4-bit counter) for aliasing and counter saturation.
module tb_pc_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_predictor_if #(.DBITS(32)) b ();
    pc_predictor_if #(.DBITS(32)) s ();
    logic [15:0] cnt;
    logic [3:0]  scnt;

    pc_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (b.slave),
        .mispredict_count (cnt)
    );

    pc_predictor #(.BTB_ENTRIES(4), .CNT_BITS(4)) sdut (
        .clk              (clk),
        .reset            (reset),
        .bus              (s.slave),
        .mispredict_count (scnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        b.res_valid = 1'b1;  b.res_pc = pc;  b.res_is_branch = br;  b.res_taken = tk;
        b.res_target = tgt;  b.res_pred_taken = ptk;  b.res_pred_target = ptgt;
    endtask

    task automatic set_sres(input logic [31:0] pc, input logic br, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        s.res_valid = 1'b1;  s.res_pc = pc;  s.res_is_branch = br;  s.res_taken = tk;
        s.res_target = tgt;  s.res_pred_taken = ptk;  s.res_pred_target = ptgt;
    endtask

    task automatic idle();
        b.res_valid = 1'b0;
        s.res_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        b.enable = 1'b0;  s.enable = 1'b0;
        set_res(0, 0, 0, 0, 0, 0);
        set_sres(0, 0, 0, 0, 0, 0);
        idle();
        tick();
        tick();

        // Reset state, then three enabled cycles of sequential fetch.
        reset = 1'b0;
        b.enable = 1'b1;
        #1;
        chk("rst_fetch_pc", b.fetch_pc, 64);
        chk("rst_pred_taken", b.pred_taken, 0);
        chk("rst_pred_target", b.pred_target, 68);
        chk("rst_flush", b.flush, 0);
        chk("rst_cnt", cnt, 0);
        tick();  chk("seq_68", b.fetch_pc, 68);  chk("seq_pt_68", b.pred_taken, 0);
        tick();  chk("seq_72", b.fetch_pc, 72);  chk("seq_pt_72", b.pred_taken, 0);
        tick();  chk("seq_76", b.fetch_pc, 76);  chk("seq_pt_76", b.pred_taken, 0);

        // Branch at 72 resolves taken to 200 but was predicted not-taken.
        set_res(72, 1, 1, 200, 0, 76);
        #1 chk("mp1_flush", b.flush, 1);
        tick();  idle();  #1;
        chk("mp1_redirect", b.fetch_pc, 200);
        chk("mp1_cnt", cnt, 1);
        chk("mp1_flush_gone", b.flush, 0);

        // Non-branch at 68 with a bogus carried target steers fetch back to 72.
        b.enable = 1'b0;
        set_res(68, 0, 0, 0, 0, 0);
        #1 chk("nb_flush", b.flush, 1);
        tick();  idle();  #1;
        chk("hit72_fetch", b.fetch_pc, 72);
        chk("hit72_taken", b.pred_taken, 1);
        chk("hit72_target", b.pred_target, 200);
        chk("hit72_cnt", cnt, 2);

        // Not-taken training #1 (ctr 2->1); same-cycle lookup still sees old entry.
        set_res(72, 1, 0, 0, 1, 200);
        #1;
        chk("nt1_flush", b.flush, 1);
        chk("nt1_old_lookup", b.pred_taken, 1);
        tick();  idle();  #1;
        chk("nt1_redirect", b.fetch_pc, 76);
        chk("nt1_cnt", cnt, 3);
        set_res(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("nt1_fetch72", b.fetch_pc, 72);
        chk("nt1_pred_taken", b.pred_taken, 0);
        chk("nt1_pred_target", b.pred_target, 76);

        // Not-taken training #2 (ctr 1->0) agrees with the prediction: no flush.
        set_res(72, 1, 0, 0, 0, 76);
        #1 chk("nt2_flush", b.flush, 0);
        tick();  idle();  #1;
        chk("nt2_hold", b.fetch_pc, 72);
        chk("nt2_cnt", cnt, 4);

        // One taken resolution from ctr=0 only reaches ctr=1: still predicts not-taken.
        set_res(72, 1, 1, 200, 0, 76);
        tick();  idle();  #1;
        chk("tk_from0_redirect", b.fetch_pc, 200);
        set_res(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("tk_from0_fetch", b.fetch_pc, 72);
        chk("tk_from0_pred", b.pred_taken, 0);
        chk("tk_from0_cnt", cnt, 6);

        // Mispredict while stalled still redirects.
        set_res(100, 1, 0, 0, 1, 300);
        #1 chk("stall_flush", b.flush, 1);
        tick();  idle();  #1;
        chk("stall_redirect", b.fetch_pc, 104);
        chk("stall_cnt", cnt, 7);
        tick();
        chk("stall_hold", b.fetch_pc, 104);

        // fetch_pc+4 wraps to zero.
        set_res(32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("wrap_fetch", b.fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_pred_target", b.pred_target, 0);
        chk("wrap_cnt", cnt, 8);
        b.enable = 1'b1;
        tick();
        b.enable = 1'b0;
        chk("wrap_zero", b.fetch_pc, 0);

        // Correctly predicted taken (ctr 1->2), then reset together with a mispredict.
        set_res(72, 1, 1, 200, 1, 200);
        #1 chk("good_pred_flush", b.flush, 0);
        tick();  idle();
        set_res(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("pre_rst_pred", b.pred_taken, 1);
        chk("pre_rst_cnt", cnt, 9);
        reset = 1'b1;
        set_res(100, 1, 1, 500, 0, 104);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mid_rst_fetch", b.fetch_pc, 64);
        chk("mid_rst_cnt", cnt, 0);
        set_res(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("post_rst_fetch", b.fetch_pc, 72);
        chk("post_rst_btb_clear", b.pred_taken, 0);
        chk("post_rst_cnt", cnt, 1);

        // Small instance: allocate 72 -> 200, then aliasing behaviour of non-branches.
        chk("s_rst_fetch", s.fetch_pc, 64);
        set_sres(72, 1, 1, 200, 0, 76);
        #1 chk("s_mp_flush", s.flush, 1);
        tick();  idle();  #1;
        chk("s_redirect", s.fetch_pc, 200);
        set_sres(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("s_hit72_taken", s.pred_taken, 1);
        chk("s_hit72_target", s.pred_target, 200);
        chk("s_cnt2", scnt, 2);

        // 88 shares the index but not the tag: no hit, entry survives.
        set_sres(88, 0, 0, 0, 0, 92);
        #1 chk("s_alias_miss_flush", s.flush, 0);
        tick();  idle();  #1;
        chk("s_alias_keep", s.pred_taken, 1);

        // Non-branch that hits 72 invalidates the entry.
        set_sres(72, 0, 0, 0, 1, 200);
        #1 chk("s_inval_flush", s.flush, 1);
        tick();  idle();  #1;
        chk("s_inval_redirect", s.fetch_pc, 76);
        chk("s_cnt3", scnt, 3);
        set_sres(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("s_inval_fetch72", s.fetch_pc, 72);
        chk("s_inval_pred", s.pred_taken, 0);
        chk("s_cnt4", scnt, 4);

        // Counter saturation at 4'hF.
        for (int i = 0; i < 11; i++) begin
            set_sres(68, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        #1 chk("s_cnt_full", scnt, 15);
        set_sres(68, 0, 0, 0, 0, 0);
        tick();  idle();  #1;
        chk("s_cnt_sat", scnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
